// File: rtl/store_merge_unit_pkg.sv
// Shared definitions for the store merge unit: access-size codes, control
// states and the request legality check used when a store is accepted.
package store_merge_unit_pkg;

  localparam logic [1:0] SIZE_WORD = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_BYTE = 2'b10;
  localparam logic [1:0] SIZE_RSVD = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_WAIT  = 3'd2,
    ST_WRITE = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // A request is illegal when its size code is reserved or it is misaligned.
  function automatic logic is_bad_request(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    case (size)
      SIZE_WORD: bad = (addr_lo != 2'b00);
      SIZE_HALF: bad = addr_lo[0];
      SIZE_BYTE: bad = 1'b0;
      default:   bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/store_merge_unit_byte_lane_merge.sv
// Little-endian lane merge: inserts the low byte/halfword of reg_data into the
// selected lane of a memory word; a word store passes reg_data straight through.
module byte_lane_merge
  import store_merge_unit_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] reg_data,
  input  logic [1:0]  size,
  input  logic [1:0]  addr_lo,
  output logic [31:0] merged
);

  // Lane selection from size and the low address bits.
  always_comb begin
    merged = word;
    case (size)
      SIZE_BYTE: begin
        case (addr_lo)
          2'd0:    merged[7:0]   = reg_data[7:0];
          2'd1:    merged[15:8]  = reg_data[7:0];
          2'd2:    merged[23:16] = reg_data[7:0];
          2'd3:    merged[31:24] = reg_data[7:0];
          default: merged        = word;
        endcase
      end
      SIZE_HALF: begin
        if (addr_lo[1]) begin
          merged[31:16] = reg_data[15:0];
        end else begin
          merged[15:0] = reg_data[15:0];
        end
      end
      SIZE_WORD: merged = reg_data;
      default:   merged = word;
    endcase
  end

endmodule

// File: rtl/store_merge_unit.sv
// Store merge unit: performs sw directly and sb/sh as read-merge-write against
// a word-wide memory with MEM_LATENCY cycles of read latency.
module store_merge_unit
  import store_merge_unit_pkg::*;
#(
  parameter int MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] reg_data,
  input  logic [31:0] mem_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  output logic        busy,
  output logic        done,
  output logic        err
);

  state_t      state_r;
  state_t      state_s;
  logic        accept_s;
  logic        capture_s;
  logic        err_req_s;
  logic [31:0] aligned_s;
  logic [31:0] merge_word_s;
  logic [31:0] merged_s;

  logic [1:0]  size_r;
  logic [31:0] addr_r;
  logic [31:0] reg_data_r;
  logic [31:0] word_r;
  logic [2:0]  cnt_r;

  logic [31:0] mem_addr_r;
  logic [31:0] mem_wdata_r;
  logic        mem_wr_r;
  logic        busy_r;
  logic        done_r;
  logic        err_r;

  assign mem_addr  = mem_addr_r;
  assign mem_wdata = mem_wdata_r;
  assign mem_wr    = mem_wr_r;
  assign busy      = busy_r;
  assign done      = done_r;
  assign err       = err_r;

  // The capture cycle merges the arriving read data; otherwise the held word.
  assign merge_word_s = capture_s ? mem_rdata : word_r;

  byte_lane_merge u_merge (
    .word     (merge_word_s),
    .reg_data (reg_data_r),
    .size     (size_r),
    .addr_lo  (addr_r[1:0]),
    .merged   (merged_s)
  );

  // Next-state logic; start is only looked at in IDLE.
  always_comb begin
    state_s   = state_r;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    err_req_s = is_bad_request(size, addr[1:0]);
    if (state_r == ST_IDLE) begin
      aligned_s = {addr[31:2], 2'b00};
    end else begin
      aligned_s = {addr_r[31:2], 2'b00};
    end
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          accept_s = 1'b1;
          if (err_req_s) begin
            state_s = ST_DONE;
          end else if (size == SIZE_WORD) begin
            state_s = ST_WRITE;
          end else begin
            state_s = ST_READ;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_READ:  state_s = ST_WAIT;
      ST_WAIT: begin
        if (cnt_r == 3'd0) begin
          capture_s = 1'b1;
          state_s   = ST_WRITE;
        end else begin
          state_s = ST_WAIT;
        end
      end
      ST_WRITE: state_s = ST_DONE;
      ST_DONE:  state_s = ST_IDLE;
      default:  state_s = ST_IDLE;
    endcase
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Request latches, read-latency counter and registered memory-side outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      size_r      <= 2'b00;
      addr_r      <= 32'd0;
      reg_data_r  <= 32'd0;
      word_r      <= 32'd0;
      cnt_r       <= 3'd0;
      mem_addr_r  <= 32'd0;
      mem_wdata_r <= 32'd0;
      mem_wr_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      err_r       <= 1'b0;
    end else begin
      mem_wr_r <= (state_s == ST_WRITE);
      busy_r   <= (state_s != ST_IDLE);
      done_r   <= (state_s == ST_DONE);
      if (state_s == ST_READ || state_s == ST_WAIT || state_s == ST_WRITE) begin
        mem_addr_r <= aligned_s;
      end else begin
        mem_addr_r <= 32'd0;
      end
      if (accept_s) begin
        size_r     <= size;
        addr_r     <= addr;
        reg_data_r <= reg_data;
        err_r      <= err_req_s;
      end
      // A word store writes the raw register value; sb/sh write the merge.
      if (accept_s && state_s == ST_WRITE) begin
        mem_wdata_r <= reg_data;
      end else if (capture_s) begin
        mem_wdata_r <= merged_s;
      end
      if (capture_s) begin
        word_r <= mem_rdata;
      end
      if (state_r == ST_READ) begin
        cnt_r <= 3'(MEM_LATENCY - 1);
      end else if (state_r == ST_WAIT && cnt_r != 3'd0) begin
        cnt_r <= cnt_r - 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_store_merge_unit.sv
// Directed bench for store_merge_unit: two instances (MEM_LATENCY 1 and 3)
// share the request inputs; per-store traces are compared to hand-worked values.
module tb_store_merge_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic [1:0]  size;
  logic [31:0] addr;
  logic [31:0] reg_data;
  logic [31:0] mem_rdata;

  logic [31:0] mem_addr_o  [2];
  logic [31:0] mem_wdata_o [2];
  logic        mem_wr_o    [2];
  logic        busy_o      [2];
  logic        done_o      [2];
  logic        err_o       [2];

  int num_checks = 0;
  int num_errors = 0;

  int          wr_cnt    [2];
  int          wr_cyc    [2];
  logic [31:0] wr_addr   [2];
  logic [31:0] wr_data   [2];
  int          done_cnt  [2];
  int          done_cyc  [2];
  int          done_cyc2 [2];
  logic        done_err  [2];
  logic        last_err  [2];
  logic        last_busy [2];
  logic [31:0] last_addr [2];

  store_merge_unit #(.MEM_LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .reg_data(reg_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_wr(mem_wr_o[0]),
    .busy(busy_o[0]), .done(done_o[0]), .err(err_o[0])
  );

  store_merge_unit #(.MEM_LATENCY(3)) dut_l3 (
    .clk(clk), .reset(reset), .start(start), .size(size), .addr(addr),
    .reg_data(reg_data), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_wr(mem_wr_o[1]),
    .busy(busy_o[1]), .done(done_o[1]), .err(err_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    num_checks++;
    if (obs !== exp) begin
      num_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Issue one store (start held for 'hold' cycles) and trace 20 cycles.
  task automatic do_store(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] d,
                          input logic [31:0] rd, input int hold);
    @(negedge clk);
    size = sz; addr = a; reg_data = d; mem_rdata = rd; start = 1'b1;
    for (int u = 0; u < 2; u++) begin
      wr_cnt[u] = 0; wr_cyc[u] = -1; wr_addr[u] = 32'd0; wr_data[u] = 32'd0;
      done_cnt[u] = 0; done_cyc[u] = -1; done_cyc2[u] = -1; done_err[u] = 1'b0;
    end
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (mem_wr_o[u]) begin
          wr_cnt[u]++;
          if (wr_cnt[u] == 1) begin
            wr_cyc[u] = k; wr_addr[u] = mem_addr_o[u]; wr_data[u] = mem_wdata_o[u];
          end
        end
        if (done_o[u]) begin
          done_cnt[u]++;
          if (done_cnt[u] == 1) begin
            done_cyc[u] = k; done_err[u] = err_o[u];
          end else begin
            done_cyc2[u] = k;
          end
        end
      end
      if (k == hold) begin
        start = 1'b0; size = 2'b11; addr = 32'hFFFF_FFFD; reg_data = 32'h0;
      end
    end
    for (int u = 0; u < 2; u++) begin
      last_err[u] = err_o[u]; last_busy[u] = busy_o[u]; last_addr[u] = mem_addr_o[u];
    end
  endtask

  task automatic check_store(input string tag, input int u, input int exp_done,
                             input int exp_wr_cyc, input int exp_wr_cnt,
                             input logic [31:0] exp_addr, input logic [31:0] exp_data,
                             input logic exp_err);
    string t;
    t = $sformatf("%s/L%0d", tag, (u == 0) ? 1 : 3);
    check_value({t, "/done_cyc"}, 32'(done_cyc[u]), 32'(exp_done));
    check_value({t, "/wr_cnt"}, 32'(wr_cnt[u]), 32'(exp_wr_cnt));
    check_value({t, "/err"}, 32'(done_err[u]), 32'(exp_err));
    check_value({t, "/err_hold"}, 32'(last_err[u]), 32'(exp_err));
    check_value({t, "/idle_addr"}, last_addr[u], 32'd0);
    check_value({t, "/idle_busy"}, 32'(last_busy[u]), 32'd0);
    if (exp_wr_cnt > 0) begin
      check_value({t, "/wr_cyc"}, 32'(wr_cyc[u]), 32'(exp_wr_cyc));
      check_value({t, "/wr_addr"}, wr_addr[u], exp_addr);
      check_value({t, "/wr_data"}, wr_data[u], exp_data);
    end
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; size = 2'b00; addr = 32'd0; reg_data = 32'd0; mem_rdata = 32'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      check_value("rst/busy", 32'(busy_o[u]), 32'd0);
      check_value("rst/done", 32'(done_o[u]), 32'd0);
      check_value("rst/mem_wr", 32'(mem_wr_o[u]), 32'd0);
      check_value("rst/mem_addr", mem_addr_o[u], 32'd0);
    end
    reset = 1'b0;

    // sb lane 2
    do_store(2'b10, 32'h0000_0102, 32'hAABB_CCDD, 32'h1122_3344, 1);
    check_store("sb102", 0, 4, 3, 1, 32'h100, 32'h11DD_3344, 1'b0);
    check_store("sb102", 1, 6, 5, 1, 32'h100, 32'h11DD_3344, 1'b0);
    // sh upper half
    do_store(2'b01, 32'h0000_0202, 32'h0000_BEEF, 32'h1234_5678, 1);
    check_store("sh202", 0, 4, 3, 1, 32'h200, 32'hBEEF_5678, 1'b0);
    check_store("sh202", 1, 6, 5, 1, 32'h200, 32'hBEEF_5678, 1'b0);
    // sw: no read phase
    do_store(2'b00, 32'h0000_0300, 32'hCAFE_F00D, 32'h0BAD_0BAD, 1);
    check_store("sw300", 0, 2, 1, 1, 32'h300, 32'hCAFE_F00D, 1'b0);
    check_store("sw300", 1, 2, 1, 1, 32'h300, 32'hCAFE_F00D, 1'b0);
    // misaligned sh and reserved size
    do_store(2'b01, 32'h0000_0201, 32'h0000_BEEF, 32'h1234_5678, 1);
    check_store("sh201", 0, 1, 0, 0, 32'h0, 32'h0, 1'b1);
    do_store(2'b11, 32'h0000_0400, 32'h1111_1111, 32'h2222_2222, 1);
    check_store("sz11", 0, 1, 0, 0, 32'h0, 32'h0, 1'b1);
    check_store("sz11", 1, 1, 0, 0, 32'h0, 32'h0, 1'b1);
    // sb top lane also clears the held err
    do_store(2'b10, 32'h0000_0103, 32'h0000_005A, 32'h0000_0000, 1);
    check_store("sb103", 0, 4, 3, 1, 32'h100, 32'h5A00_0000, 1'b0);
    // sh lower half ignores reg_data[31:16]
    do_store(2'b01, 32'h0000_0200, 32'hFFFF_1234, 32'h0F0F_0F0F, 1);
    check_store("sh200", 0, 4, 3, 1, 32'h200, 32'h0F0F_1234, 1'b0);
    check_store("sh200", 1, 6, 5, 1, 32'h200, 32'h0F0F_1234, 1'b0);
    // sb lane 0 then misaligned sw leaves err set ahead of the reset test
    do_store(2'b10, 32'h0000_0100, 32'h0000_0099, 32'h1122_3344, 1);
    check_store("sb100", 0, 4, 3, 1, 32'h100, 32'h1122_3399, 1'b0);
    do_store(2'b00, 32'h0000_0302, 32'hDEAD_BEEF, 32'h0, 1);
    check_store("sw302", 0, 1, 0, 0, 32'h0, 32'h0, 1'b1);

    // reset while both instances sit in WAIT
    @(negedge clk);
    size = 2'b10; addr = 32'h0000_0101; reg_data = 32'h0000_0077; mem_rdata = 32'hAAAA_AAAA; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    for (int u = 0; u < 2; u++) begin
      check_value("midrst/busy", 32'(busy_o[u]), 32'd0);
      check_value("midrst/err", 32'(err_o[u]), 32'd0);
      check_value("midrst/mem_addr", mem_addr_o[u], 32'd0);
      check_value("midrst/mem_wdata", mem_wdata_o[u], 32'd0);
      check_value("midrst/mem_wr", 32'(mem_wr_o[u]), 32'd0);
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    for (int u = 0; u < 2; u++) wr_cnt[u] = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      for (int u = 0; u < 2; u++) begin
        if (mem_wr_o[u]) wr_cnt[u]++;
      end
    end
    check_value("midrst/no_wr_l1", 32'(wr_cnt[0]), 32'd0);
    check_value("midrst/no_wr_l3", 32'(wr_cnt[1]), 32'd0);
    do_store(2'b10, 32'h0000_0101, 32'h0000_0077, 32'hAAAA_AAAA, 1);
    check_store("postrst", 0, 4, 3, 1, 32'h100, 32'hAAAA_77AA, 1'b0);
    check_store("postrst", 1, 6, 5, 1, 32'h100, 32'hAAAA_77AA, 1'b0);

    // start held for 10 cycles: a second store only after IDLE
    do_store(2'b10, 32'h0000_0102, 32'hAABB_CCDD, 32'h1122_3344, 10);
    check_value("hold/L3/done1", 32'(done_cyc[1]), 32'd6);
    check_value("hold/L3/wr1", 32'(wr_cyc[1]), 32'd5);
    check_value("hold/L3/done2", 32'(done_cyc2[1]), 32'd13);
    check_value("hold/L3/wr_cnt", 32'(wr_cnt[1]), 32'd2);
    check_value("hold/L3/wdata", wr_data[1], 32'h11DD_3344);
    check_value("hold/L1/done1", 32'(done_cyc[0]), 32'd4);
    check_value("hold/L1/done2", 32'(done_cyc2[0]), 32'd9);
    check_value("hold/L1/wr_cnt", 32'(wr_cnt[0]), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
    $finish;
  end

endmodule

// File: doc/store_merge_unit.md
STORE_MERGE_UNIT -- requirements
Module: store_merge_unit

Interface
REQ-001 The module SHALL have parameter MEM_LATENCY, default 1: cycles from read address issue to valid mem_rdata; legal range 1..4.
REQ-002 The module SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 The module SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-004 The module SHALL have port start, input, 1: request a store; sampled only in IDLE.
REQ-005 The module SHALL have port size, input, 2: 00 word (sw), 01 halfword (sh), 10 byte (sb), 11 reserved.
REQ-006 The module SHALL have port addr, input, 32: byte address of the store.
REQ-007 The module SHALL have port reg_data, input, 32: rt value; low byte or low halfword is used for sb and sh.
REQ-008 The module SHALL have port mem_rdata, input, 32: word read from memory.
REQ-009 The module SHALL have port mem_addr, output, 32: word-aligned address {addr[31:2],2'b00}.
REQ-010 The module SHALL have port mem_wdata, output, 32: merged word to write.
REQ-011 The module SHALL have port mem_wr, output, 1: memory write strobe, exactly one cycle per store.
REQ-012 The module SHALL have port busy, output, 1: high in every state except IDLE.
REQ-013 The module SHALL have port done, output, 1: one-cycle pulse on completion, including error completion.
REQ-014 The module SHALL have port err, output, 1: set with done when the request was misaligned or size=11; held until the next accepted start.

Function
REQ-015 The module SHALL latch size, addr and reg_data on the edge that accepts start, and SHALL ignore all later changes to those inputs until done.
REQ-016 The module SHALL implement states IDLE, READ, WAIT, WRITE, DONE.
REQ-017 From IDLE with start=1, the module SHALL go to WRITE for a word store, to READ for sh/sb, and to DONE with err=1 for an error.
REQ-018 An error SHALL be size=11, sh with addr[0]=1, or sw with addr[1:0]!=00; no mem_wr SHALL occur for an error.
REQ-019 READ SHALL drive mem_addr with mem_wr=0 for one cycle; WAIT SHALL count MEM_LATENCY-1 further cycles, then capture mem_rdata into an internal word register.
REQ-020 Merging SHALL be little-endian: for sb, lane addr[1:0] (0 = bits 7:0, ... 3 = bits 31:24) takes reg_data[7:0]; for sh, addr[1]=0 selects bits 15:0 and addr[1]=1 selects bits 31:16, taking reg_data[15:0]; all other bits SHALL equal the captured word.
REQ-021 For sw, mem_wdata SHALL equal the latched reg_data and no read SHALL occur.
REQ-022 WRITE SHALL assert mem_wr=1 for exactly one cycle with mem_addr and mem_wdata stable; the next state SHALL be DONE.
REQ-023 DONE SHALL pulse done=1 for one cycle and then return to IDLE; start asserted during DONE SHALL be ignored.
REQ-024 Latency from the start-accept edge to done high SHALL be 2 cycles for sw, 3+MEM_LATENCY for sh/sb, and 1 for an error.
REQ-025 start asserted while busy=1 SHALL be ignored without side effects.
REQ-026 mem_addr SHALL hold the latched aligned address from READ through WRITE, and SHALL be 0 in IDLE.

Reset
REQ-027 Assertion of reset SHALL immediately force IDLE with mem_wr=0, done=0, err=0, busy=0, mem_addr=0, mem_wdata=0, and the captured word cleared, including mid-operation; a write aborted by reset SHALL NOT be reissued.
REQ-028 After reset deassertion, the first start SHALL be accepted on the next rising edge.

Structure
REQ-029 The size codes (WORD/HALF/BYTE) and state encodings SHALL reside in a shared include file that is also used by the control unit.
REQ-030 The lane merge SHALL be a combinational sub-module, byte_lane_merge (inputs: word, reg_data, size, addr[1:0]; output: merged word).

Verification
REQ-031 sb with addr=0x0000_0102, reg_data=0xAABB_CCDD, mem_rdata=0x1122_3344 -> exactly one mem_wr with mem_addr=0x100 and mem_wdata=0x11DD_3344; done at cycle 4 (MEM_LATENCY=1).
REQ-032 sh with addr=0x202, reg_data=0x0000_BEEF, mem_rdata=0x1234_5678 -> mem_wdata=0xBEEF_5678, mem_addr=0x200.
REQ-033 sw with addr=0x300, reg_data=0xCAFE_F00D -> no read cycle, mem_wr at cycle 1, done at cycle 2, mem_wdata=0xCAFE_F00D.
REQ-034 sh with addr=0x201, and separately size=11 -> done at cycle 1, err=1, mem_wr never asserted.
REQ-035 Reset asserted during WAIT -> outputs cleared asynchronously, no mem_wr; a following sb completes normally.
REQ-036 start held high for 10 cycles with MEM_LATENCY=3 -> exactly one store, done at cycle 6, and a second store accepted only after returning to IDLE.
